// File: rtl/dict_pkg.sv
// Shared definitions for the string-to-integer and integer-to-string dictionaries.
package dict_pkg;

  localparam logic OP_SET = 1'b0;
  localparam logic OP_GET = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } dict_state_e;

endpackage

// File: rtl/dict_is_mem.sv
// Value/key pair storage: one asynchronous read port, one synchronous write port.
module dict_is_mem #(
  parameter int unsigned ENTRIES = 10,
  parameter int unsigned AW      = 4,
  parameter int unsigned VW      = 32,
  parameter int unsigned KW      = 64
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [VW-1:0] i_wvalue,
  input  logic [KW-1:0] i_wkey,
  input  logic [AW-1:0] i_raddr,
  output logic [VW-1:0] o_rvalue,
  output logic [KW-1:0] o_rkey
);

  logic [VW-1:0] val_q [ENTRIES];
  logic [KW-1:0] key_q [ENTRIES];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      val_q[i_waddr] <= i_wvalue;
      key_q[i_waddr] <= i_wkey;
    end
  end

  // The scan index reaches ENTRIES on a full-table miss; that slot does not exist.
  always_comb begin
    o_rvalue = '0;
    o_rkey   = '0;
    if (i_raddr < AW'(ENTRIES)) begin
      o_rvalue = val_q[i_raddr];
      o_rkey   = key_q[i_raddr];
    end
  end

endmodule

// File: rtl/dict_is.sv
// Integer-to-string reverse dictionary: sequential scan by value, one entry per cycle.
module dict_is
  import dict_pkg::*;
#(
  parameter int unsigned ENTRIES     = 10,
  parameter int unsigned KEY_WIDTH   = 8,
  parameter int unsigned KEY_LENGTH  = 8,
  parameter int unsigned VALUE_WIDTH = 32
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_en,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic                             i_op,
  input  logic [VALUE_WIDTH-1:0]           i_value,
  input  logic [KEY_WIDTH*KEY_LENGTH-1:0]  i_key,
  output logic                             o_done,
  output logic                             o_found,
  output logic                             o_full,
  output logic [KEY_WIDTH*KEY_LENGTH-1:0]  o_key,
  output logic [$clog2(ENTRIES+1)-1:0]     o_count
);

  localparam int unsigned KW = KEY_WIDTH * KEY_LENGTH;
  localparam int unsigned CW = $clog2(ENTRIES + 1);

  dict_state_e           state_q, state_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  op_q, op_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic [KW-1:0]         key_q, key_d;
  logic                  found_q, found_d;
  logic                  full_q, full_d;
  logic [KW-1:0]         okey_q, okey_d;

  logic                  wr_en;
  logic [VALUE_WIDTH-1:0] rd_value;
  logic [KW-1:0]         rd_key;
  logic                  hit;

  dict_is_mem #(
    .ENTRIES (ENTRIES),
    .AW      (CW),
    .VW      (VALUE_WIDTH),
    .KW      (KW)
  ) u_mem (
    .i_clk    (i_clk),
    .i_we     (wr_en & i_en),
    .i_waddr  (idx_q),
    .i_wvalue (value_q),
    .i_wkey   (key_q),
    .i_raddr  (idx_q),
    .o_rvalue (rd_value),
    .o_rkey   (rd_key)
  );

  assign hit = (idx_q < count_q) && (rd_value == value_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    op_d    = op_q;
    value_d = value_q;
    key_d   = key_q;
    found_d = found_q;
    full_d  = full_q;
    okey_d  = okey_q;
    wr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          op_d    = i_op;
          value_d = i_value;
          key_d   = i_key;
          idx_d   = '0;
          found_d = 1'b0;
          full_d  = 1'b0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // A miss always lands at idx == count, so the write slot is idx in both cases.
        if (hit) begin
          state_d = ST_DONE;
          found_d = 1'b1;
          if (op_q == OP_GET) okey_d = rd_key;
          else                wr_en  = 1'b1;
        end else if (idx_q == count_q) begin
          state_d = ST_DONE;
          found_d = 1'b0;
          if (op_q == OP_GET) begin
            okey_d = '0;
          end else if (count_q < CW'(ENTRIES)) begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
          end else begin
            full_d = 1'b1;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      count_q <= '0;
      op_q    <= OP_SET;
      value_q <= '0;
      key_q   <= '0;
      found_q <= 1'b0;
      full_q  <= 1'b0;
      okey_q  <= '0;
    end else if (i_en) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      op_q    <= op_d;
      value_q <= value_d;
      key_q   <= key_d;
      found_q <= found_d;
      full_q  <= full_d;
      okey_q  <= okey_d;
    end
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_done  = (state_q == ST_DONE);
  assign o_found = found_q;
  assign o_full  = full_q;
  assign o_key   = okey_q;
  assign o_count = count_q;

endmodule

// File: doc/dict_is.md
# dict_is

Integer-to-string reverse dictionary for the Forth core: stores (value, key) pairs and answers "which name belongs to this integer" queries, e.g. mapping an execution-token address back to its word name for `SEE`/trace output. Lookup is by value, the opposite direction of the string-to-integer word dictionary. Entries are scanned sequentially, one per cycle, behind a valid/ready request handshake with a single-cycle done pulse.

## Interface
- ENTRIES, 10, number of storage slots
- KEY_WIDTH, 8, bits per key character
- KEY_LENGTH, 8, characters per key; unused trailing characters are 0
- VALUE_WIDTH, 32, bits per value
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_en  input  1  clock enable; low freezes all state and outputs
- i_valid  input  1  request present
- o_ready  output  1  block idle, request accepted when i_valid & o_ready & i_en
- i_op  input  1  0 = SET (store key under value), 1 = GET (find key for value)
- i_value  input  VALUE_WIDTH  lookup/store value, sampled at accept
- i_key  input  KEY_WIDTH*KEY_LENGTH  key for SET, char 0 in LSBs, sampled at accept
- o_done  output  1  one-cycle completion pulse
- o_found  output  1  valid with o_done: value matched an existing entry
- o_full  output  1  valid with o_done: SET failed, no free slot
- o_key  output  KEY_WIDTH*KEY_LENGTH  GET result, valid with o_done, held until next accept
- o_count  output  $clog2(ENTRIES+1)  occupied entries

## Operation
- States: IDLE, SCAN, DONE. o_ready = 1 only in IDLE.
- IDLE: on accept, latch i_op/i_value/i_key, idx <= 0, go SCAN.
- SCAN (one entry per cycle): if idx < count and value[idx] == latched value → hit; else if idx == count → miss; else idx <= idx+1.
- GET hit: o_key <= key[idx], o_found <= 1. GET miss: o_key <= 0, o_found <= 0.
- SET hit: key[idx] <= latched key (overwrite), o_found <= 1. SET miss with count < ENTRIES: append at slot count, count+1, o_found <= 0. SET miss with count == ENTRIES: no write, o_full <= 1.
- Hit/miss → DONE: o_done = 1 for exactly that cycle, then IDLE.
- Values are unique by construction; first match wins.
- No delete; only reset empties the table.

## Timing
- Reset: state IDLE, count 0, o_ready 1, o_done 0, o_found 0, o_full 0, o_key 0. Storage contents need not be cleared (masked by count).
- Accept at cycle T. Hit at index k: o_done at T+2+k. Miss with N entries: o_done at T+2+N (empty table: T+2).
- o_found/o_full/o_key update on the SCAN→DONE edge, hold through IDLE until next accept; o_found/o_full cleared at accept.
- Next accept earliest the cycle after o_done (o_ready high in IDLE).
- i_en low: no state change, no accept, o_done held at its current level until i_en returns.
- i_valid while busy: ignored; requester must hold it until accepted.
- Reset mid-scan: abort, return to reset values; no partial write.
- o_count updates the cycle the append is written (with o_done).

## Structure
- Shared package dict_pkg: OP_SET/OP_GET constants, state encoding (shared with the string-to-integer dictionary).
- Sub-module dict_is_mem: ENTRIES-deep storage of value/key pairs, one read port addressed by idx, one write port; dict_is holds FSM, counters, and compare.

## Test plan
- Empty GET: reset, GET 0x1000 → o_done at T+2, o_found 0, o_key 0, o_count 0.
- Append/lookup: SET 0x1000 "DUP", SET 0x2000 "SWAP"; GET 0x2000 → o_done at T+3, o_found 1, o_key "SWAP", o_count 2.
- Overwrite: SET 0x1000 "DROP" after above → o_found 1, o_count stays 2; GET 0x1000 → "DROP".
- Full: fill 10 distinct values, SET new 0x9999 → o_done at T+12, o_full 1, o_count 10; SET existing value still succeeds with o_found 1.
- Stall: drop i_en for 3 cycles mid-scan → o_done delayed exactly 3 cycles, same result; i_valid during SCAN ignored.
- Reset mid-scan: assert i_rst during SET append scan → o_count 0, o_ready 1, subsequent GET misses.
